// File: rtl/lex_mtime_pkg.sv
// lex_mtime_pkg: shared constants, types and helpers for the machine timer.
//   MTIME_ADDR_WIDTH      byte-address bits of the timer window
//   *_OFFSET_*            register byte offsets within the window
//   DEFAULT_MTIME_CLK_DIV default clk cycles per mtime increment
//   apply_strobe()        byte-granular merge of write data into a 32-bit register
package lex_mtime_pkg;

    typedef logic [31:0] word_t;

    localparam int          MTIME_ADDR_WIDTH      = 4;
    localparam logic [3:0]  MTIME_OFFSET_LO       = 4'h0;
    localparam logic [3:0]  MTIME_OFFSET_HI       = 4'h4;
    localparam logic [3:0]  MTIMECMP_OFFSET_LO    = 4'h8;
    localparam logic [3:0]  MTIMECMP_OFFSET_HI    = 4'hC;
    localparam int          DEFAULT_MTIME_CLK_DIV = 100;

    // Bytes whose strobe bit is set take the new value; the rest keep the old one.
    function automatic word_t apply_strobe(input word_t old_w, input word_t new_w,
                                           input logic [3:0] strb);
        word_t rv;
        for (int i = 0; i < 4; i++) begin
            rv[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return rv;
    endfunction

endpackage

// File: rtl/lex_mtime_if.sv
// lex_mtime_if: simple request/response bus between the LSU and the timer.
//   bus_en/bus_we/bus_addr/bus_wr_data/bus_wr_strobe  request, driven by the master
//   bus_rd_data/bus_ack/bus_err                        response, driven by the slave
interface lex_mtime_if;
    import lex_mtime_pkg::*;

    logic                        bus_en;
    logic                        bus_we;
    logic [MTIME_ADDR_WIDTH-1:0] bus_addr;
    word_t                       bus_wr_data;
    logic [3:0]                  bus_wr_strobe;
    word_t                       bus_rd_data;
    logic                        bus_ack;
    logic                        bus_err;

    modport master (
        output bus_en, bus_we, bus_addr, bus_wr_data, bus_wr_strobe,
        input  bus_rd_data, bus_ack, bus_err
    );

    modport slave (
        input  bus_en, bus_we, bus_addr, bus_wr_data, bus_wr_strobe,
        output bus_rd_data, bus_ack, bus_err
    );

endinterface

// File: rtl/lex_tick_gen.sv
// lex_tick_gen: prescaler producing one tick every CLK_DIV clock cycles.
//   clk   in   system clock
//   rst   in   synchronous active-high reset (counter back to 0)
//   tick  out  high on the cycle the prescaler sits at CLK_DIV-1 (its wrap cycle)
module lex_tick_gen #(
    parameter int CLK_DIV = 100
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    generate
        if (CLK_DIV <= 1) begin : g_nodiv
            // Every cycle is a tick; the clock and reset are not needed here.
            logic unused_in;
            assign unused_in = clk ^ rst;
            assign tick      = 1'b1;
        end else begin : g_div
            localparam int          CW   = $clog2(CLK_DIV);
            localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

            logic [CW-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (rst)              r_cnt <= '0;
                else if (r_cnt == LAST) r_cnt <= '0;
                else                  r_cnt <= r_cnt + 1'b1;
            end

            assign tick = (r_cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/lex_mtime.sv
// lex_mtime: RISC-V machine timer, bus target for mtime/mtimecmp.
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-high reset
//   bus     slave modport of lex_mtime_if (1-cycle ack, no stall)
//   time_o  out  current mtime, combinational from the register
//   mtip    out  registered (mtime >= mtimecmp)
module lex_mtime
    import lex_mtime_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_MTIME_CLK_DIV
) (
    input  logic          clk,
    input  logic          rst,
    lex_mtime_if.slave    bus,
    output logic [63:0]   time_o,
    output logic          mtip
);

    logic        w_tick;
    logic        w_aligned;
    logic        w_wr;
    word_t       w_rd_val;
    logic [63:0] w_mtime_nxt;
    logic [63:0] w_cmp_nxt;

    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_ack;
    logic        r_err;
    word_t       r_rd_data;
    logic        r_mtip;

    lex_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    assign w_aligned = (bus.bus_addr[1:0] == 2'b00);
    // A zero-strobe write changes nothing, so it is not treated as a write at all.
    assign w_wr      = bus.bus_en & bus.bus_we & w_aligned & (|bus.bus_wr_strobe);

    always_comb begin
        w_rd_val = '0;
        case (bus.bus_addr)
            MTIME_OFFSET_LO:    w_rd_val = r_mtime[31:0];
            MTIME_OFFSET_HI:    w_rd_val = r_mtime[63:32];
            MTIMECMP_OFFSET_LO: w_rd_val = r_mtimecmp[31:0];
            MTIMECMP_OFFSET_HI: w_rd_val = r_mtimecmp[63:32];
            default:            w_rd_val = '0;
        endcase
    end

    // A write to either mtime half replaces the increment for that cycle: the
    // unwritten bytes keep their pre-increment value and the tick is simply lost.
    always_comb begin
        w_mtime_nxt = w_tick ? r_mtime + 64'd1 : r_mtime;
        w_cmp_nxt   = r_mtimecmp;
        if (w_wr) begin
            case (bus.bus_addr)
                MTIME_OFFSET_LO:
                    w_mtime_nxt = {r_mtime[63:32],
                                   apply_strobe(r_mtime[31:0], bus.bus_wr_data, bus.bus_wr_strobe)};
                MTIME_OFFSET_HI:
                    w_mtime_nxt = {apply_strobe(r_mtime[63:32], bus.bus_wr_data, bus.bus_wr_strobe),
                                   r_mtime[31:0]};
                MTIMECMP_OFFSET_LO:
                    w_cmp_nxt = {r_mtimecmp[63:32],
                                 apply_strobe(r_mtimecmp[31:0], bus.bus_wr_data, bus.bus_wr_strobe)};
                MTIMECMP_OFFSET_HI:
                    w_cmp_nxt = {apply_strobe(r_mtimecmp[63:32], bus.bus_wr_data, bus.bus_wr_strobe),
                                 r_mtimecmp[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mtime    <= '0;
            r_mtimecmp <= '1;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_rd_data  <= '0;
            r_mtip     <= 1'b0;
        end else begin
            r_mtime    <= w_mtime_nxt;
            r_mtimecmp <= w_cmp_nxt;
            r_ack      <= bus.bus_en;
            r_err      <= bus.bus_en & ~w_aligned;
            // Read data reflects the registers before this edge's update.
            r_rd_data  <= (bus.bus_en & ~bus.bus_we & w_aligned) ? w_rd_val : '0;
            r_mtip     <= (r_mtime >= r_mtimecmp);
        end
    end

    assign bus.bus_ack     = r_ack;
    assign bus.bus_err     = r_err;
    assign bus.bus_rd_data = r_rd_data;
    assign time_o          = r_mtime;
    assign mtip            = r_mtip;

endmodule

// File: tb/tb_lex_mtime.sv
module tb_lex_mtime;
    import lex_mtime_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] time_o;
    logic        mtip;
    int          total = 0;
    int          bad   = 0;

    lex_mtime_if bus();

    lex_mtime #(.CLK_DIV(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .time_o (time_o),
        .mtip   (mtip)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wd;
        logic [3:0]  st;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts just after a negedge, ends at the negedge after the accepting edge.
    task automatic xfer(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, output logic ack, output logic err,
                        output logic [31:0] rd);
        bus.bus_en        = 1'b1;
        bus.bus_we        = we;
        bus.bus_addr      = addr;
        bus.bus_wr_data   = wd;
        bus.bus_wr_strobe = st;
        @(negedge clk);
        ack = bus.bus_ack;
        err = bus.bus_err;
        rd  = bus.bus_rd_data;
        bus.bus_en        = 1'b0;
        bus.bus_we        = 1'b0;
        bus.bus_wr_strobe = 4'h0;
    endtask

    vec_t        vt [12];
    logic        ack, err;
    logic [31:0] rd;
    logic [63:0] prev;
    logic        seen;

    initial begin
        bus.bus_en = 1'b0; bus.bus_we = 1'b0; bus.bus_addr = 4'h0;
        bus.bus_wr_data = '0; bus.bus_wr_strobe = 4'h0;

        vt[0]  = '{1'b1, 4'h8, 32'h1234_5678, 4'hF, 1'b0, 32'h0};
        vt[1]  = '{1'b0, 4'h8, 32'h0,         4'h0, 1'b0, 32'h1234_5678};
        vt[2]  = '{1'b1, 4'hC, 32'h9ABC_DEF0, 4'h3, 1'b0, 32'h0};
        vt[3]  = '{1'b0, 4'hC, 32'h0,         4'h0, 1'b0, 32'h0000_DEF0};
        vt[4]  = '{1'b0, 4'h2, 32'h0,         4'h0, 1'b1, 32'h0};
        vt[5]  = '{1'b1, 4'hA, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0};
        vt[6]  = '{1'b0, 4'h8, 32'h0,         4'h0, 1'b0, 32'h1234_5678};
        vt[7]  = '{1'b1, 4'h8, 32'h0,         4'h0, 1'b0, 32'h0};
        vt[8]  = '{1'b0, 4'h8, 32'h0,         4'h0, 1'b0, 32'h1234_5678};
        vt[9]  = '{1'b1, 4'h8, 32'hAABB_CCDD, 4'h8, 1'b0, 32'h0};
        vt[10] = '{1'b0, 4'h8, 32'h0,         4'h0, 1'b0, 32'hAA34_5678};
        vt[11] = '{1'b1, 4'hE, 32'h5555_5555, 4'hF, 1'b1, 32'h0};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ack", {63'd0, bus.bus_ack}, 64'd0);
        chk("rst_err", {63'd0, bus.bus_err}, 64'd0);
        chk("rst_rd", {32'd0, bus.bus_rd_data}, 64'd0);
        chk("rst_mtip", {63'd0, mtip}, 64'd0);
        chk("rst_time", time_o, 64'd0);

        // free-running count: 40 clocks at CLK_DIV=4
        rst = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("t1_time", time_o, 64'd10);
        chk("t1_mtip", {63'd0, mtip}, 64'd0);

        // carry from low into high word
        xfer(1'b1, 4'h4, 32'h0, 4'hF, ack, err, rd);
        xfer(1'b1, 4'h0, 32'hFFFF_FFFF, 4'hF, ack, err, rd);
        chk("t2_wr_ack", {62'd0, ack, err}, 64'd2);
        prev = time_o;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (time_o != prev) seen = 1'b1;
        end
        chk("t2_tick_seen", {63'd0, seen}, 64'd1);
        xfer(1'b0, 4'h0, 32'h0, 4'h0, ack, err, rd);
        chk("t2_rd_lo", {32'd0, rd}, 64'd0);
        xfer(1'b0, 4'h4, 32'h0, 4'h0, ack, err, rd);
        chk("t2_rd_hi", {32'd0, rd}, 64'd1);

        // compare and interrupt timing
        xfer(1'b1, 4'h4, 32'h0, 4'hF, ack, err, rd);
        xfer(1'b1, 4'h0, 32'd18, 4'hF, ack, err, rd);
        xfer(1'b1, 4'h8, 32'd20, 4'hF, ack, err, rd);
        xfer(1'b1, 4'hC, 32'd0, 4'hF, ack, err, rd);
        chk("t3_mtip_pre", {63'd0, mtip}, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            prev = time_o;
            @(negedge clk);
            chk("t3_mtip_lag", {63'd0, mtip}, {63'd0, (prev >= 64'd20)});
            if (mtip && prev == 64'd20) seen = 1'b1;
        end
        chk("t3_rise_at_20", {63'd0, seen}, 64'd1);
        xfer(1'b1, 4'hC, 32'd1, 4'hF, ack, err, rd);
        chk("t3_mtip_hold", {63'd0, mtip}, 64'd1);
        @(negedge clk);
        chk("t3_mtip_clear", {63'd0, mtip}, 64'd0);

        // byte-strobed write to the high word
        xfer(1'b1, 4'h4, 32'hAABB_CCDD, 4'b0101, ack, err, rd);
        xfer(1'b0, 4'h4, 32'h0, 4'h0, ack, err, rd);
        chk("t4_rd_hi", {32'd0, rd}, 64'h0000_0000_00BB_00DD);
        xfer(1'b1, 4'h4, 32'h0, 4'hF, ack, err, rd);

        // table: mtimecmp access, errors, zero strobe
        for (int i = 0; i < 12; i++) begin
            xfer(vt[i].we, vt[i].addr, vt[i].wd, vt[i].st, ack, err, rd);
            chk($sformatf("vec%0d_ack", i), {63'd0, ack}, 64'd1);
            chk($sformatf("vec%0d_err", i), {63'd0, err}, {63'd0, vt[i].exp_err});
            chk($sformatf("vec%0d_rd", i), {32'd0, rd}, {32'd0, vt[i].exp_rd});
        end
        xfer(1'b0, 4'hC, 32'h0, 4'h0, ack, err, rd);
        chk("t5_cmp_hi_kept", {32'd0, rd}, 64'h0000_DEF0);
        xfer(1'b1, 4'h5, 32'hFFFF_FFFF, 4'hF, ack, err, rd);
        chk("t5_mis_err", {63'd0, err}, 64'd1);
        chk("t5_hi_untouched", {32'd0, time_o[63:32]}, 64'd0);
        @(negedge clk);
        chk("t5_idle_rd", {61'd0, bus.bus_ack, bus.bus_err, |bus.bus_rd_data}, 64'd0);

        // write coinciding with a tick: tick is lost, not deferred
        prev = time_o;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (time_o != prev) seen = 1'b1;
        end
        chk("t6_tick_seen", {63'd0, seen}, 64'd1);
        repeat (3) @(negedge clk);
        xfer(1'b1, 4'h0, 32'd5, 4'hF, ack, err, rd);
        chk("t6_lo_5", time_o, 64'd5);
        repeat (3) @(negedge clk);
        chk("t6_no_defer", time_o, 64'd5);
        @(negedge clk);
        chk("t6_next_tick", time_o, 64'd6);

        // reset while a request is presented
        rst = 1'b1;
        bus.bus_en = 1'b1; bus.bus_we = 1'b0; bus.bus_addr = 4'h0;
        @(negedge clk);
        bus.bus_en = 1'b0;
        chk("t7_no_ack", {63'd0, bus.bus_ack}, 64'd0);
        chk("t7_rd", {32'd0, bus.bus_rd_data}, 64'd0);
        chk("t7_time", time_o, 64'd0);
        chk("t7_mtip", {63'd0, mtip}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        xfer(1'b0, 4'hC, 32'h0, 4'h0, ack, err, rd);
        chk("t7_cmp_reset", {32'd0, rd}, 64'hFFFF_FFFF);
        chk("t7_mtip_after", {63'd0, mtip}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
